mdu_sequencer: RTL and testbench



---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_datapath.sv | 81 ++++++++
 rtl/mdu_sequencer.sv | 58 +++++
 tb/tb_mdu_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the RV32M multiply/divide sequencer
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;
  localparam int STEPS = 32;
  localparam logic [4:0] LAST_STEP = 5'(STEPS - 1);
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_REM = 32'h0000_0000;
endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: operand magnitudes, shared 33-bit adder/subtractor, accumulator and sign fix-up
module mdu_datapath
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        fix,
  input  logic [2:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        fast,
  output logic [31:0] result
);
  mdu_op_e     op_in, op_q;
  logic        a_sgn, b_sgn, a_neg, b_neg, a_neg_q, b_neg_q;
  logic        is_div, div0, ovf, ge;
  logic [31:0] a_mag, b_mag, fast_val;
  logic [31:0] hi, lo, mcand;
  logic [32:0] sh, add_a, add_b, sum;
  logic [63:0] prod, prod_s;
  logic [31:0] quot_s, rem_s, sel;
  // accept-time decode: signedness, magnitudes and the divide special cases
  always_comb begin
    op_in = mdu_op_e'(op);
    a_sgn = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_sgn = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_neg = a_sgn & opa[31];
    b_neg = b_sgn & opb[31];
    a_mag = a_neg ? -opa : opa;
    b_mag = b_neg ? -opb : opb;
    div0 = opb == '0;
    ovf = (op_in inside {OP_DIV, OP_REM}) && opa == OVF_DIVIDEND && opb == OVF_DIVISOR;
    fast = op[2] & (div0 | ovf);
    fast_val = div0 ? (op[1] ? opa : DIV_ZERO_Q) : (op[1] ? OVF_REM : OVF_DIVIDEND);
  end
  // one adder serves both: hi + multiplicand for multiply, shifted rem - divisor for divide
  always_comb begin
    is_div = op_q[2];
    sh = {hi, lo[31]};
    add_a = is_div ? {1'b0, sh[31:0]} : {1'b0, hi};
    add_b = is_div ? ~{1'b0, mcand} : (lo[0] ? {1'b0, mcand} : 33'd0);
    sum = add_a + add_b + {32'd0, is_div};
    ge = sh[32] | ~sum[32];
  end
  // sign restoration and output word selection
  always_comb begin
    prod = {hi, lo};
    prod_s = (a_neg_q ^ b_neg_q) ? -prod : prod;
    quot_s = (a_neg_q ^ b_neg_q) ? -lo : lo;
    rem_s = a_neg_q ? -hi : hi;
    sel = op_q == OP_MUL ? prod_s[31:0] : !op_q[2] ? prod_s[63:32] : !op_q[1] ? quot_s : rem_s;
  end
  // accumulator load/step and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= OP_MUL;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      hi <= '0;
      lo <= '0;
      mcand <= '0;
      result <= '0;
    end else begin
      if (load) begin
        op_q <= op_in;
        a_neg_q <= a_neg;
        b_neg_q <= b_neg;
        hi <= '0;
        lo <= op[2] ? a_mag : b_mag;
        mcand <= op[2] ? b_mag : a_mag;
        if (fast) result <= fast_val;
      end else if (step) begin
        hi <= is_div ? (ge ? sum[31:0] : sh[31:0]) : sum[32:1];
        lo <= is_div ? {lo[30:0], ge} : {sum[0], lo[31:1]};
      end
      if (fix) result <= sel;
    end
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: FSM, step counter and start/busy/done handshake for the RV32M unit
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  mdu_state_e state, nxt;
  logic [4:0] cnt;
  logic       accept, fast;
  // state and step counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= (accept || state != CALC) ? '0 : cnt + 5'd1;
    end
  end
  // next state and handshake outputs; flush overrides everything
  always_comb begin
    accept = state == IDLE && start && !flush;
    nxt = state;
    if (flush) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = accept ? (fast ? DONE : CALC) : IDLE;
        CALC:    nxt = cnt == LAST_STEP ? FIX : CALC;
        FIX:     nxt = DONE;
        default: nxt = IDLE;
      endcase
    busy = state != IDLE;
    done = state == DONE;
  end
  mdu_datapath u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (state == CALC),
    .fix   (state == FIX && !flush),
    .op    (op),
    .opa   (opa),
    .opb   (opb),
    .fast  (fast),
    .result(result)
  );
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench with an arithmetic reference model
module tb_mdu_sequencer;
  logic clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [2:0] op = 0;
  logic [31:0] opa = 0, opb = 0;
  logic busy, done;
  logic [31:0] result;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [31:0] val; int at;} exp_t;
  exp_t sb[$];

  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, ua, ub;
    logic [63:0] p;
    logic ovf;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    r = 0;
    case (o)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb_; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb_);
      3'd5: r = b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: r = b == 0 ? a : ovf ? 32'd0 : 32'(sa % sb_);
      default: r = b == 0 ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy got 1 expected 0 within 100 cycles");
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
    @(negedge clk);
    wait_idle();
    op = o;
    opa = a;
    opb = b;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    if (track) sb.push_back('{model(o, a, b), cyc + (is_fast(o, a, b) ? 0 : 33)});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (result %h)", result);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.val);
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] d_op[9] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd7, 3'd5, 3'd6, 3'd4};
    logic [31:0] d_a[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'd100, 32'h1234_5678, 32'd5, 32'h8000_0000};
    logic [31:0] d_b[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                            32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] held;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_result", result, 0);
    rst_n = 1;

    @(negedge clk);
    op = 3'd0; opa = 7; opb = 6; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    sb.push_back('{32'd42, cyc + 33});
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_c%0d", k), 32'(busy), 32'(k <= 34));
      chk($sformatf("mul_done_c%0d", k), 32'(done), 32'(k == 34));
    end

    for (int i = 0; i < 9; i++) issue(d_op[i], d_a[i], d_b[i], 1);

    @(negedge clk);
    wait_idle();
    held = result;
    issue(3'd4, 32'd1000, 32'd3, 0);
    repeat (10) @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_result", result, held);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd123, 32'd456, 1);

    @(negedge clk);
    wait_idle();
    start = 1; flush = 1; op = 3'd0; opa = 3; opb = 3;
    @(posedge clk);
    #1;
    start = 0; flush = 0;
    @(negedge clk);
    chk("flush_start_busy", 32'(busy), 0);

    issue(3'd0, 32'd3, 32'd5, 1);
    repeat (5) @(negedge clk);
    op = 3'd5; opa = 9; opb = 2; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    wait_idle();
    repeat (40) @(negedge clk);

    issue(3'd0, 32'd11, 32'd13, 0);
    repeat (5) @(negedge clk);
    op = 3'd5; opa = 9; opb = 2; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (15) @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_result", result, 0);
    rst_n = 1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 150; i++) issue(3'($urandom_range(0, 7)), pick(), pick(), 1);

    @(negedge clk);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
